// File: rtl/fxp_arith_unit.sv
// -----------------------------------------------------------------------------
// fxp_arith_unit
// Registered signed fixed-point arithmetic unit (add / multiply / divide) on
// two's-complement Q(DATA_WIDTH-FIXED_PNT).(FIXED_PNT) operands, shared behind
// one start/busy/data_ready handshake.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        request, sampled only while busy=0
//   op           00 add, 01 mult, 10 div, 11 treated as add
//   num1, num2   signed operands (dividend / divisor for div)
//   result       signed result, held until the next completion
//   overflow     true result above max positive
//   underflow    true result below min negative
//   div_by_zero  last completed div had num2 == 0
//   busy         division in progress
//   data_ready   one-cycle pulse aligned with each result update
//
// Build option:
//   FXP_SATURATE_EN  when defined, out-of-range results clamp to max positive /
//                    min negative; otherwise they wrap to the low DATA_WIDTH
//                    bits. Divide-by-zero results are saturated in both builds.
//
// Add and mult complete at the accept edge. Div runs a restoring divider on
// magnitudes, one quotient bit per cycle for DATA_WIDTH+FIXED_PNT cycles, and
// completes one edge later with the sign applied.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module fxp_arith_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int FIXED_PNT  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] num1,
    input  logic [DATA_WIDTH-1:0] num2,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  div_by_zero,
    output logic                  busy,
    output logic                  data_ready
);
    localparam int DW = DATA_WIDTH;
    localparam int N  = DATA_WIDTH + FIXED_PNT;   // divider iterations
    localparam int CW = $clog2(N + 1);
    localparam int XW = 2 * DATA_WIDTH + 1;       // wide enough for any true result
    localparam logic [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DIV  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [DW-1:0] r_result;
    logic          r_overflow;
    logic          r_underflow;
    logic          r_div_by_zero;
    logic          r_data_ready;

    // divider state
    logic [DW-1:0] r_rem;
    logic [DW-1:0] r_dvsr;
    logic [N-1:0]  r_quo;       // dividend bits shift out the top, quotient bits shift in
    logic          r_neg;
    logic          r_n1_neg;
    logic          r_dz;
    logic [CW-1:0] r_cnt;

    logic w_accept;
    logic w_div_done;
    assign w_accept   = start && (r_state == S_IDLE);
    assign w_div_done = (r_state == S_DIV) && (r_cnt == CW'(N));

    // ---------------- add / mult ----------------
    logic signed [DW:0]      w_sum;
    logic signed [2*DW-1:0]  w_n1_x;
    logic signed [2*DW-1:0]  w_n2_x;
    logic signed [2*DW-1:0]  w_prod;
    logic signed [2*DW-1:0]  w_prod_sh;
    logic signed [XW-1:0]    w_add_x;
    logic signed [XW-1:0]    w_mul_x;

    assign w_sum     = $signed({num1[DW-1], num1}) + $signed({num2[DW-1], num2});
    assign w_n1_x    = {{DW{num1[DW-1]}}, num1};
    assign w_n2_x    = {{DW{num2[DW-1]}}, num2};
    assign w_prod    = w_n1_x * w_n2_x;               // exact: |product| <= 2^(2*DW-2)
    assign w_prod_sh = w_prod >>> FIXED_PNT;          // floor rounding
    assign w_add_x   = {{(XW-DW-1){w_sum[DW]}}, w_sum};
    assign w_mul_x   = {w_prod_sh[2*DW-1], w_prod_sh};

    // ---------------- divider ----------------
    logic [DW-1:0] w_abs1;
    logic [DW-1:0] w_abs2;
    logic [DW:0]   w_rem_sh;
    logic          w_ge;
    logic [DW-1:0] w_rem_diff;
    logic [XW-1:0] w_q_x;
    logic signed [XW-1:0] w_div_x;

    assign w_abs1     = num1[DW-1] ? (-num1) : num1;  // -MIN_NEG reads correctly as unsigned
    assign w_abs2     = num2[DW-1] ? (-num2) : num2;
    assign w_rem_sh   = {r_rem, r_quo[N-1]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_dvsr});
    // When w_ge holds the difference is below the divisor, so low bits suffice.
    assign w_rem_diff = w_rem_sh[DW-1:0] - r_dvsr;
    assign w_q_x      = {{(XW-N){1'b0}}, r_quo};
    assign w_div_x    = r_neg ? -w_q_x : w_q_x;

    // ---------------- range check / result formatting ----------------
    logic signed [XW-1:0] w_true_x;
    logic                 w_ov;
    logic                 w_un;
    logic [DW-1:0]        w_res;

    always_comb begin
        w_true_x = w_add_x;
        if (r_state == S_DIV) begin
            w_true_x = w_div_x;
        end else if (op == 2'b01) begin
            w_true_x = w_mul_x;
        end
    end

    // In range iff every bit from DW-1 upward equals the sign bit.
    assign w_ov = !w_true_x[XW-1] &&  (|w_true_x[XW-2:DW-1]);
    assign w_un =  w_true_x[XW-1] && !(&w_true_x[XW-2:DW-1]);

`ifdef FXP_SATURATE_EN
    assign w_res = w_ov ? MAX_POS : (w_un ? MIN_NEG : w_true_x[DW-1:0]);
`else
    assign w_res = w_true_x[DW-1:0];
`endif

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && (op == 2'b10)) w_state_next = S_DIV;
            S_DIV:   if (w_div_done) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result      <= '0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
            r_div_by_zero <= 1'b0;
            r_data_ready  <= 1'b0;
            r_rem         <= '0;
            r_dvsr        <= '0;
            r_quo         <= '0;
            r_neg         <= 1'b0;
            r_n1_neg      <= 1'b0;
            r_dz          <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_data_ready <= 1'b0;
            if (w_accept) begin
                if (op == 2'b10) begin
                    r_rem    <= '0;
                    r_quo    <= {w_abs1, {FIXED_PNT{1'b0}}};
                    r_dvsr   <= w_abs2;
                    r_neg    <= num1[DW-1] ^ num2[DW-1];
                    r_n1_neg <= num1[DW-1];
                    r_dz     <= (num2 == '0);
                    r_cnt    <= '0;
                end else begin
                    r_result      <= w_res;
                    r_overflow    <= w_ov;
                    r_underflow   <= w_un;
                    r_div_by_zero <= 1'b0;
                    r_data_ready  <= 1'b1;
                end
            end else if (r_state == S_DIV) begin
                if (w_div_done) begin
                    if (r_dz) begin
                        // quotient is meaningless here; saturate by dividend sign
                        r_result    <= r_n1_neg ? MIN_NEG : MAX_POS;
                        r_overflow  <= !r_n1_neg;
                        r_underflow <= r_n1_neg;
                    end else begin
                        r_result    <= w_res;
                        r_overflow  <= w_ov;
                        r_underflow <= w_un;
                    end
                    r_div_by_zero <= r_dz;
                    r_data_ready  <= 1'b1;
                end else begin
                    r_rem <= w_ge ? w_rem_diff : w_rem_sh[DW-1:0];
                    r_quo <= {r_quo[N-2:0], w_ge};
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign result      = r_result;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;
    assign div_by_zero = r_div_by_zero;
    assign data_ready  = r_data_ready;
    assign busy        = (r_state == S_DIV);

endmodule

// File: tb/tb_fxp_arith_unit.sv
`timescale 1ns/1ps
module tb_fxp_arith_unit;
    localparam int DW      = 16;
    localparam int FP      = 8;
    localparam int DIV_LAT = DW + FP + 1;
    localparam int MAX_WAIT = 40;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [15:0] num1  = 16'h0000;
    logic [15:0] num2  = 16'h0000;
    logic [15:0] result;
    logic        overflow;
    logic        underflow;
    logic        div_by_zero;
    logic        busy;
    logic        data_ready;

    int n_checks = 0;
    int n_pass   = 0;

    fxp_arith_unit #(.DATA_WIDTH(DW), .FIXED_PNT(FP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .num1        (num1),
        .num2        (num2),
        .result      (result),
        .overflow    (overflow),
        .underflow   (underflow),
        .div_by_zero (div_by_zero),
        .busy        (busy),
        .data_ready  (data_ready)
    );

    always #5 clk = ~clk;

    // Reference: true mathematical result with wide integers, then range rules.
    // Returns {result[15:0], overflow, underflow, div_by_zero}.
    function automatic logic [18:0] model(input logic [1:0] f_op, input logic [15:0] a,
                                          input logic [15:0] b);
        longint sa;
        longint sb;
        longint t;
        logic ov;
        logic un;
        logic dz;
        logic [15:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        t  = 0;
        dz = 1'b0;
        case (f_op)
            2'b01:   t = (sa * sb) >>> FP;
            2'b10: begin
                if (sb == 0) dz = 1'b1;
                else         t = (sa * (longint'(1) << FP)) / sb;
            end
            default: t = sa + sb;
        endcase
        if (dz) begin
            ov = (sa >= 0);
            un = (sa < 0);
            r  = ov ? 16'h7FFF : 16'h8000;
        end else begin
            ov = (t > 32767);
            un = (t < -32768);
            r  = t[15:0];
`ifdef FXP_SATURATE_EN
            if (ov) r = 16'h7FFF;
            if (un) r = 16'h8000;
`endif
        end
        return {r, ov, un, dz};
    endfunction

    // Drive one request and wait (bounded) for data_ready.
    // lat = edges after the accept edge at which data_ready was seen.
    task automatic run_op(input logic [1:0] f_op, input logic [15:0] a, input logic [15:0] b,
                          output int lat, output logic busy_acc);
        @(negedge clk);
        op = f_op; num1 = a; num2 = b; start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        busy_acc = busy;
        lat      = 0;
        while (!data_ready && lat < MAX_WAIT) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        #1;
        if ({result, overflow, underflow, div_by_zero, busy, data_ready} !== 21'd0) begin
            $display("FAIL reset_during got=%h/%b%b%b busy=%b dr=%b exp all zero",
                     result, overflow, underflow, div_by_zero, busy, data_ready);
        end else n_pass++;
        n_checks++;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        if ({result, overflow, underflow, div_by_zero, busy, data_ready} !== 21'd0) begin
            $display("FAIL reset_after got=%h/%b%b%b busy=%b dr=%b exp all zero",
                     result, overflow, underflow, div_by_zero, busy, data_ready);
        end else n_pass++;
        n_checks++;
        $display("reset: outputs idle");
    endtask

    task automatic test_directed();
        logic [1:0]  t_op [14] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00,
                                   2'b10, 2'b00, 2'b10, 2'b01, 2'b10, 2'b11, 2'b01};
        logic [15:0] t_a  [14] = '{16'h0180, 16'h0180, 16'h0001, 16'h0300, 16'hFD00, 16'h7F00,
                                   16'h8000, 16'h0100, 16'h0100, 16'hFF00, 16'h8000, 16'h8000,
                                   16'h0100, 16'h7FFF};
        logic [15:0] t_b  [14] = '{16'h0240, 16'hFE00, 16'h0080, 16'h0200, 16'h0200, 16'h0200,
                                   16'hFF00, 16'h0000, 16'h0100, 16'h0000, 16'h8000, 16'hFFFF,
                                   16'h0200, 16'h7FFF};
        int lat;
        logic busy_acc;
        logic [18:0] exp_v;
        for (int i = 0; i < 14; i++) begin
            exp_v = model(t_op[i], t_a[i], t_b[i]);
            run_op(t_op[i], t_a[i], t_b[i], lat, busy_acc);
            $display("directed op=%0d a=%h b=%h -> result=%h ov=%b un=%b dz=%b lat=%0d",
                     t_op[i], t_a[i], t_b[i], result, overflow, underflow, div_by_zero, lat);
            if (lat !== ((t_op[i] == 2'b10) ? DIV_LAT : 0)) begin
                $display("FAIL directed_latency[%0d] got=%0d exp=%0d", i, lat,
                         (t_op[i] == 2'b10) ? DIV_LAT : 0);
            end else n_pass++;
            n_checks++;
            if (busy_acc !== (t_op[i] == 2'b10)) begin
                $display("FAIL directed_busy_accept[%0d] got=%b exp=%b", i, busy_acc, t_op[i] == 2'b10);
            end else n_pass++;
            n_checks++;
            if ({result, overflow, underflow, div_by_zero} !== exp_v) begin
                $display("FAIL directed_result[%0d] got=%h/%b%b%b exp=%h/%b%b%b", i,
                         result, overflow, underflow, div_by_zero,
                         exp_v[18:3], exp_v[2], exp_v[1], exp_v[0]);
            end else n_pass++;
            n_checks++;
        end
    endtask

    task automatic test_random_arith();
        logic [1:0]  r_op;
        logic [15:0] a;
        logic [15:0] b;
        int lat;
        logic busy_acc;
        logic [18:0] exp_v;
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 2))
                0:       r_op = 2'b00;
                1:       r_op = 2'b01;
                default: r_op = 2'b11;
            endcase
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 1) == 1) a = {{5{a[10]}}, a[10:0]};
            if ($urandom_range(0, 1) == 1) b = {{5{b[10]}}, b[10:0]};
            exp_v = model(r_op, a, b);
            run_op(r_op, a, b, lat, busy_acc);
            $display("rand_arith op=%0d a=%h b=%h -> result=%h ov=%b un=%b", r_op, a, b,
                     result, overflow, underflow);
            if (lat !== 0 || {result, overflow, underflow, div_by_zero} !== exp_v) begin
                $display("FAIL rand_arith[%0d] got=%h/%b%b%b lat=%0d exp=%h/%b%b%b lat=0", i,
                         result, overflow, underflow, div_by_zero, lat,
                         exp_v[18:3], exp_v[2], exp_v[1], exp_v[0]);
            end else n_pass++;
            n_checks++;
        end
    endtask

    task automatic test_random_div();
        logic [15:0] a;
        logic [15:0] b;
        int lat;
        logic busy_acc;
        logic [18:0] exp_v;
        for (int i = 0; i < 12; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 1) == 1) b = {{8{b[7]}}, b[7:0]};
            if (i == 5) b = 16'h0000;
            exp_v = model(2'b10, a, b);
            run_op(2'b10, a, b, lat, busy_acc);
            $display("rand_div a=%h b=%h -> result=%h ov=%b un=%b dz=%b", a, b,
                     result, overflow, underflow, div_by_zero);
            if (lat !== DIV_LAT || busy !== 1'b0 || {result, overflow, underflow, div_by_zero} !== exp_v) begin
                $display("FAIL rand_div[%0d] got=%h/%b%b%b lat=%0d busy=%b exp=%h/%b%b%b lat=%0d busy=0", i,
                         result, overflow, underflow, div_by_zero, lat, busy,
                         exp_v[18:3], exp_v[2], exp_v[1], exp_v[0], DIV_LAT);
            end else n_pass++;
            n_checks++;
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  b_op [6];
        logic [15:0] b_a  [6];
        logic [15:0] b_b  [6];
        logic [18:0] exp_v;
        for (int i = 0; i < 6; i++) begin
            b_op[i] = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00;
            b_a[i]  = 16'($urandom);
            b_b[i]  = {{6{1'b0}}, 10'($urandom)};
        end
        @(negedge clk);
        op = b_op[0]; num1 = b_a[0]; num2 = b_b[0]; start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            exp_v = model(b_op[i], b_a[i], b_b[i]);
            $display("b2b op=%0d a=%h b=%h -> result=%h dr=%b", b_op[i], b_a[i], b_b[i],
                     result, data_ready);
            if (data_ready !== 1'b1 || {result, overflow, underflow, div_by_zero} !== exp_v) begin
                $display("FAIL b2b[%0d] got=%h/%b%b%b dr=%b exp=%h/%b%b%b dr=1", i,
                         result, overflow, underflow, div_by_zero, data_ready,
                         exp_v[18:3], exp_v[2], exp_v[1], exp_v[0]);
            end else n_pass++;
            n_checks++;
            if (i < 5) begin
                op = b_op[i+1]; num1 = b_a[i+1]; num2 = b_b[i+1];
            end else begin
                start = 1'b0;
            end
        end
        @(posedge clk); #1;
        if (data_ready !== 1'b0) begin
            $display("FAIL b2b_pulse_end got dr=%b exp=0", data_ready);
        end else n_pass++;
        n_checks++;
    endtask

    task automatic test_busy_ignore();
        int lat;
        @(negedge clk);
        op = 2'b10; num1 = 16'h0300; num2 = 16'h0200; start = 1'b1;
        @(posedge clk); #1;
        // keep requesting an add while the divider is busy
        op = 2'b00; num1 = 16'h0001; num2 = 16'h0001;
        lat = 0;
        while (!data_ready && lat < MAX_WAIT) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 10) start = 1'b0;
        end
        $display("busy_ignore div 0300/0200 -> result=%h lat=%0d", result, lat);
        if (lat !== DIV_LAT || result !== 16'h0180 || overflow !== 1'b0) begin
            $display("FAIL busy_ignore got=%h ov=%b lat=%0d exp=0180 ov=0 lat=%0d",
                     result, overflow, lat, DIV_LAT);
        end else n_pass++;
        n_checks++;
        @(posedge clk); #1;
        if (data_ready !== 1'b0 || result !== 16'h0180) begin
            $display("FAIL busy_ignore_no_extra got dr=%b result=%h exp dr=0 result=0180",
                     data_ready, result);
        end else n_pass++;
        n_checks++;
    endtask

    task automatic test_reset_mid_div();
        int lat;
        logic busy_acc;
        logic seen_dr;
        run_op(2'b00, 16'h0100, 16'h0100, lat, busy_acc);   // leave a nonzero result
        @(negedge clk);
        op = 2'b10; num1 = 16'h0300; num2 = 16'h0200; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        if ({result, overflow, underflow, div_by_zero, busy, data_ready} !== 21'd0) begin
            $display("FAIL reset_mid_div got=%h/%b%b%b busy=%b dr=%b exp all zero",
                     result, overflow, underflow, div_by_zero, busy, data_ready);
        end else n_pass++;
        n_checks++;
        @(negedge clk); rst_n = 1'b1;
        seen_dr = 1'b0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk); #1;
            seen_dr = seen_dr | data_ready | busy;
        end
        if (seen_dr !== 1'b0) begin
            $display("FAIL reset_mid_div_no_ready got activity=%b exp=0", seen_dr);
        end else n_pass++;
        n_checks++;
        run_op(2'b00, 16'h0180, 16'h0240, lat, busy_acc);
        $display("post_reset add 0180+0240 -> result=%h lat=%0d", result, lat);
        if (lat !== 0 || {result, overflow, underflow, div_by_zero} !== model(2'b00, 16'h0180, 16'h0240)) begin
            $display("FAIL post_reset_add got=%h/%b%b%b lat=%0d exp=03c0/000 lat=0",
                     result, overflow, underflow, div_by_zero, lat);
        end else n_pass++;
        n_checks++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random_arith();
        test_random_div();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_div();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fxp_arith_unit.md
Name: fxp_arith_unit

Overview:
- Registered signed fixed-point arithmetic unit: add, multiply, divide on two's-complement Q(DATA_WIDTH-FIXED_PNT).(FIXED_PNT) operands.
- Internally contains an adder, a multiplier and an iterative divider, behind a common start/ready handshake.
- Used as the shared arithmetic engine for the series and exponent datapaths, e.g. exp evaluation.

Parameters:
- DATA_WIDTH, 16, total operand/result width in bits, signed.
- FIXED_PNT, 8, number of fractional bits; must satisfy 0 < FIXED_PNT < DATA_WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only while busy=0.
- op  input  2  operation: 00 add, 01 mult, 10 div, 11 reserved (treated as add).
- num1  input  DATA_WIDTH  signed operand A (dividend for div).
- num2  input  DATA_WIDTH  signed operand B (divisor for div).
- result  output  DATA_WIDTH  signed result, held until the next completion.
- overflow  output  1  true result > max positive (0x7FFF at defaults).
- underflow  output  1  true result < min negative (0x8000 at defaults).
- div_by_zero  output  1  last div had num2 == 0.
- busy  output  1  division in progress.
- data_ready  output  1  one-cycle pulse coinciding with result update.

Behaviour:
- Reset (async, rst_n=0):
  - result, overflow, underflow, div_by_zero, busy, data_ready all 0.
  - Any division in progress is aborted; no data_ready is produced for it.
- Accept: on a rising edge with start=1 and busy=0, num1, num2 and op are captured. start while busy=1 is ignored; there is no queueing.
- Add: exact sum computed at DATA_WIDTH+1 bits. Result and flags registered at the accept edge. data_ready=1 for exactly the next cycle.
- Mult:
  - Full 2*DATA_WIDTH signed product, arithmetically shifted right by FIXED_PNT (floor rounding).
  - Range check against DATA_WIDTH.
  - Same 1-cycle latency as add.
- Div:
  - Quotient = (num1 << FIXED_PNT) / num2, truncated toward zero.
  - Restoring division on magnitudes, one quotient bit per cycle, N = DATA_WIDTH+FIXED_PNT iterations.
  - Sign applied at the end; result range-checked.
  - busy goes to 1 at the accept edge. Result, flags and data_ready are updated at accept edge + N + 1, and busy returns to 0 at that same edge.
  - A new start is accepted on the first edge where busy=0.
- Divide by zero:
  - Fixed latency N+1, same as a normal div.
  - num1 >= 0: result = max positive, overflow=1.
  - num1 < 0: result = min negative, underflow=1.
  - div_by_zero=1 in both cases.
- Flags:
  - overflow, underflow and div_by_zero are registered with result and held until the next completion.
  - At most one of overflow/underflow is set.
  - div_by_zero is cleared by any non-div completion.
- Range violation (not saturated): without the optional feature, result = low DATA_WIDTH bits of the true result (wrap); flags are still set.
- Quirk: min negative / -1 (div), and min × min (mult), overflow and follow the same flag rules.
- data_ready never asserts for two consecutive cycles except on back-to-back add/mult starts, where it stays high with a new result each cycle.

Optional Feature:
- FXP_SATURATE_EN defined: on overflow, result clamps to max positive; on underflow, to min negative. Flags are unchanged.
- FXP_SATURATE_EN undefined: result wraps (two's-complement truncation) as described above.
- Divide-by-zero results are saturated in both builds.

Test Plan:
- Add, defaults: num1=0x0180 (1.5), num2=0x0240 (2.25), op=00 → next cycle result=0x03C0, data_ready pulse, no flags.
- Mult: 0x0180 × 0xFE00 (1.5 × -2.0), op=01 → result=0xFD00 (-3.0), 1-cycle latency. Also 0x0001 × 0x0080 → 0x0000 (floor).
- Div: 0x0300 / 0x0200, op=10 → busy for 25 edges; result=0x0180, data_ready at accept+25. Also 0xFD00 / 0x0200 → 0xFE80 (-1.5). A start asserted mid-division is ignored.
- Overflow: 0x7F00 + 0x0200 → overflow=1; result=0x7FFF with FXP_SATURATE_EN, 0x8100 without. 0x8000 + 0xFF00 → underflow=1.
- Divide by zero: 0x0100 / 0x0000 → result=0x7FFF, overflow=1, div_by_zero=1. 0xFF00 / 0x0000 → 0x8000, underflow=1.
- Reset mid-div: assert rst_n=0 asynchronously 10 cycles into a div → all outputs 0 immediately; no data_ready after release. A new add then completes normally.
